// File: rtl/uart_rx_frame_decoder_if.sv
// Serial-side signals of the UART receive decoder: the line and tick enable in,
// the decoded word and status strobes out.
interface uart_rx_frame_decoder_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_Tick;
    logic                 i_Rx_Data;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Rx_Done;
    logic                 o_Rx_Frame_Err;
    logic                 o_Rx_Active;

    // master feeds the line and tick; slave is the decoder itself
    modport master (
        output i_Rx_Tick, i_Rx_Data,
        input  o_Rx_Byte, o_Rx_Done, o_Rx_Frame_Err, o_Rx_Active
    );

    modport slave (
        input  i_Rx_Tick, i_Rx_Data,
        output o_Rx_Byte, o_Rx_Done, o_Rx_Frame_Err, o_Rx_Active
    );
endinterface

// File: rtl/uart_rx_frame_decoder.sv
// UART 8N1-style receive decoder: oversample-tick driven frame recovery with
// LSB-first data, one-cycle done / framing-error strobes and break handling.
module uart_rx_frame_decoder #(
    parameter int RX_OVERSAMPLE = 16,
    parameter int DATA_BITS     = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    uart_rx_frame_decoder_if.slave  rx_if
);
    localparam int TICK_W = $clog2(RX_OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RX_OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;

    // NOTE: synchroniser resets to the idle-high line level so release from
    // reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '1;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx_if.i_Rx_Data};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // NOTE: every sequential update uses <= so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: defaults first so no path through the case infers a latch; the
    // strobes default low, which is what makes them one clk wide.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (rx_if.i_Rx_Tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        // right shift: the first (LSB) bit ends up in bit 0
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rx_s) begin
                            byte_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_if.o_Rx_Byte      = byte_q;
    assign rx_if.o_Rx_Done      = done_q;
    assign rx_if.o_Rx_Frame_Err = err_q;
    assign rx_if.o_Rx_Active    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Self-checking bench for uart_rx_frame_decoder: directed frames plus random
// frames scored against a frame-level model of the serial protocol.
module tb_uart_rx_frame_decoder;
    localparam int OS = 16;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int   tick_period = 4;
    int   stall_req = 0;

    int   done_cnt = 0, err_cnt = 0, width_err = 0, overlap_err = 0;
    logic [DB-1:0] got [256];
    logic prev_done = 1'b0, prev_err = 1'b0;

    logic [DB-1:0] model_byte = '0;

    uart_rx_frame_decoder_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_frame_decoder #(.RX_OVERSAMPLE(OS), .DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_if   (rx_if)
    );

    always #5 clk = ~clk;

    // tick generator: one tick every tick_period clks, with optional 10-clk stalls
    initial begin
        int cnt = 0;
        int stall_left = 0;
        int stall_seen = 0;
        rx_if.i_Rx_Tick = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_req != stall_seen) begin
                stall_seen = stall_req;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                stall_left--;
                rx_if.i_Rx_Tick = 1'b0;
            end else if (cnt >= tick_period - 1) begin
                cnt = 0;
                rx_if.i_Rx_Tick = 1'b1;
            end else begin
                cnt++;
                rx_if.i_Rx_Tick = 1'b0;
            end
        end
    end

    // strobe monitor: records each done pulse's byte and any pulse-shape violation
    always @(negedge clk) begin
        if (rx_if.o_Rx_Done === 1'b1) begin
            if (prev_done) width_err++;
            else begin
                got[done_cnt & 255] = rx_if.o_Rx_Byte;
                done_cnt++;
            end
        end
        if (rx_if.o_Rx_Frame_Err === 1'b1) begin
            if (prev_err) width_err++;
            else err_cnt++;
        end
        if (rx_if.o_Rx_Done === 1'b1 && rx_if.o_Rx_Frame_Err === 1'b1) overlap_err++;
        prev_done = rx_if.o_Rx_Done;
        prev_err  = rx_if.o_Rx_Frame_Err;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (rx_if.i_Rx_Tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        @(negedge clk);
        rx_if.i_Rx_Data = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input int stall_bit);
        send_bit(1'b0, OS);
        for (int i = 0; i < DB; i++) begin
            if (i == stall_bit) stall_req++;
            send_bit(d[i], OS);
        end
        send_bit(stop_v, OS);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rx_if.o_Rx_Byte, rx_if.o_Rx_Done, rx_if.o_Rx_Frame_Err, rx_if.o_Rx_Active} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got byte=%h done=%b err=%b active=%b, want all 0",
                     rx_if.o_Rx_Byte, rx_if.o_Rx_Done, rx_if.o_Rx_Frame_Err, rx_if.o_Rx_Active);
        end
        reset_n = 1'b1;
        wait_ticks(8);
        checks++;
        if (rx_if.o_Rx_Active !== 1'b0 || done_cnt != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL idle_after_reset: active=%b done=%0d err=%0d, want 0/0/0",
                     rx_if.o_Rx_Active, done_cnt, err_cnt);
        end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt, e0 = err_cnt;
        send_bit(1'b0, 4);
        send_bit(1'b1, 24);
        @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            failures++;
            $display("FAIL glitch_strobes: done=%0d err=%0d, want 0/0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (rx_if.o_Rx_Byte !== 8'h00 || rx_if.o_Rx_Active !== 1'b0) begin
            failures++;
            $display("FAIL glitch_state: byte=%h active=%b, want 00/0", rx_if.o_Rx_Byte, rx_if.o_Rx_Active);
        end
    endtask

    task automatic test_basic();
        logic [DB-1:0] d = 8'hA5;
        int d0 = done_cnt, e0 = err_cnt;
        send_bit(1'b0, OS);
        @(negedge clk);
        checks++;
        if (rx_if.o_Rx_Active !== 1'b1) begin
            failures++;
            $display("FAIL active_in_frame: got %b want 1", rx_if.o_Rx_Active);
        end
        for (int i = 0; i < DB; i++) send_bit(d[i], OS);
        @(negedge clk);
        checks++;
        if (rx_if.o_Rx_Active !== 1'b1 || done_cnt != d0) begin
            failures++;
            $display("FAIL active_before_stop: active=%b done=%0d, want 1/0", rx_if.o_Rx_Active, done_cnt - d0);
        end
        send_bit(1'b1, OS);
        wait_ticks(4);
        @(negedge clk);
        model_byte = d;
        checks++;
        if (done_cnt != d0 + 1 || err_cnt != e0) begin
            failures++;
            $display("FAIL basic_strobes: done=%0d err=%0d, want 1/0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (rx_if.o_Rx_Byte !== model_byte || got[d0 & 255] !== model_byte) begin
            failures++;
            $display("FAIL basic_byte: got %h (strobed %h) want %h", rx_if.o_Rx_Byte, got[d0 & 255], model_byte);
        end
        checks++;
        if (rx_if.o_Rx_Active !== 1'b0) begin
            failures++;
            $display("FAIL active_after_stop: got %b want 0", rx_if.o_Rx_Active);
        end
    endtask

    task automatic test_frame_err();
        int d0 = done_cnt, e0 = err_cnt;
        send_frame(8'h3C, 1'b0, -1);
        send_bit(1'b0, 40);
        send_bit(1'b1, 8);
        @(negedge clk);
        checks++;
        if (err_cnt != e0 + 1 || done_cnt != d0) begin
            failures++;
            $display("FAIL frame_err_strobes: err=%0d done=%0d, want 1/0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (rx_if.o_Rx_Byte !== model_byte) begin
            failures++;
            $display("FAIL frame_err_byte_held: got %h want %h", rx_if.o_Rx_Byte, model_byte);
        end
        d0 = done_cnt;
        send_frame(8'h81, 1'b1, -1);
        wait_ticks(4);
        @(negedge clk);
        model_byte = 8'h81;
        checks++;
        if (done_cnt != d0 + 1 || rx_if.o_Rx_Byte !== model_byte) begin
            failures++;
            $display("FAIL after_err_decode: done=%0d byte=%h, want 1/%h", done_cnt - d0, rx_if.o_Rx_Byte, model_byte);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        wait_ticks(4);
        @(negedge clk);
        model_byte = 8'hFF;
        checks++;
        if (done_cnt != d0 + 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses want 2", done_cnt - d0);
        end
        checks++;
        if (got[d0 & 255] !== 8'h00 || got[(d0 + 1) & 255] !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_order: got %h,%h want 00,ff", got[d0 & 255], got[(d0 + 1) & 255]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DB-1:0] d = 8'h55;
        int d0 = done_cnt, e0 = err_cnt;
        send_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) send_bit(d[i], OS);
        send_bit(d[4], 8);
        @(negedge clk);
        reset_n = 1'b0;
        rx_if.i_Rx_Data = 1'b1;
        @(negedge clk);
        checks++;
        if ({rx_if.o_Rx_Byte, rx_if.o_Rx_Done, rx_if.o_Rx_Frame_Err, rx_if.o_Rx_Active} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: byte=%h done=%b err=%b active=%b, want all 0",
                     rx_if.o_Rx_Byte, rx_if.o_Rx_Done, rx_if.o_Rx_Frame_Err, rx_if.o_Rx_Active);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_byte = '0;
        wait_ticks(20);
        @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0 || rx_if.o_Rx_Byte !== model_byte) begin
            failures++;
            $display("FAIL aborted_frame: done=%0d err=%0d byte=%h, want 0/0/00",
                     done_cnt - d0, err_cnt - e0, rx_if.o_Rx_Byte);
        end
        send_frame(8'hC3, 1'b1, -1);
        wait_ticks(4);
        @(negedge clk);
        model_byte = 8'hC3;
        checks++;
        if (done_cnt != d0 + 1 || rx_if.o_Rx_Byte !== model_byte) begin
            failures++;
            $display("FAIL post_reset_decode: done=%0d byte=%h, want 1/%h", done_cnt - d0, rx_if.o_Rx_Byte, model_byte);
        end
    endtask

    task automatic test_tick_modes();
        int d0, w0;
        for (int mode = 0; mode < 2; mode++) begin
            tick_period = (mode == 0) ? 1 : 7;
            d0 = done_cnt;
            w0 = width_err;
            send_bit(1'b1, 4);
            send_frame(8'h6E, 1'b1, (mode == 0) ? -1 : $urandom_range(1, DB - 1));
            wait_ticks(4);
            @(negedge clk);
            model_byte = 8'h6E;
            checks++;
            if (done_cnt != d0 + 1 || got[d0 & 255] !== model_byte) begin
                failures++;
                $display("FAIL tick_mode%0d_decode: done=%0d byte=%h want 1/%h",
                         mode, done_cnt - d0, got[d0 & 255], model_byte);
            end
            checks++;
            if (width_err != w0) begin
                failures++;
                $display("FAIL tick_mode%0d_pulse_width: %0d wide pulses, want 0", mode, width_err - w0);
            end
        end
    endtask

    task automatic test_random();
        logic [DB-1:0] d;
        logic stop_ok;
        int d0, e0;
        for (int n = 0; n < 6; n++) begin
            tick_period = $urandom_range(1, 5);
            d = DB'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(d, stop_ok, -1);
            if (!stop_ok) begin
                send_bit(1'b0, $urandom_range(0, 20));
                send_bit(1'b1, 6);
            end else begin
                wait_ticks(4);
                model_byte = d;
            end
            @(negedge clk);
            checks++;
            if (done_cnt != d0 + (stop_ok ? 1 : 0) || err_cnt != e0 + (stop_ok ? 0 : 1)
                || rx_if.o_Rx_Byte !== model_byte) begin
                failures++;
                $display("FAIL random%0d: data=%h stop=%b done=%0d err=%0d byte=%h want byte=%h",
                         n, d, stop_ok, done_cnt - d0, err_cnt - e0, rx_if.o_Rx_Byte, model_byte);
            end
        end
        checks++;
        if (overlap_err != 0 || width_err != 0) begin
            failures++;
            $display("FAIL strobe_shape: overlap=%0d wide=%0d want 0/0", overlap_err, width_err);
        end
    endtask

    initial begin
        rx_if.i_Rx_Data = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_glitch();
        test_basic();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_modes();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_decoder.md
Name: uart_rx_frame_decoder

Overview:
- Single-clock UART receive decoder: the far end of the UART transmit path.
- Takes the serial line plus a one-cycle oversample tick enable from the baud generator and recovers 8N1 (parameterisable data width) frames, LSB first.
- Reports each good byte with a one-cycle done strobe and flags framing errors.
- Runs on the system clock; baud timing comes only through the tick enable, not a derived clock.

Parameters:
- RX_OVERSAMPLE, 16, ticks per bit period; even, >= 4
- DATA_BITS, 8, data bits per frame; 5..9
- SYNC_STAGES, 2, flops in the serial-input synchroniser; >= 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- i_Rx_Tick  in  1  oversample enable, high for one clk, RX_OVERSAMPLE pulses per bit
- i_Rx_Data  in  1  asynchronous serial line, idle high
- o_Rx_Byte  out  DATA_BITS  last correctly framed data word
- o_Rx_Done  out  1  one-clk pulse, o_Rx_Byte newly valid
- o_Rx_Frame_Err  out  1  one-clk pulse, stop bit sampled low
- o_Rx_Active  out  1  high while a frame is being decoded (states START, DATA, STOP)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; tick counter, bit counter and shift register = 0; synchroniser flops = 1.
  - o_Rx_Byte=0, o_Rx_Done=0, o_Rx_Frame_Err=0, o_Rx_Active=0.
  - Reset asserted mid-frame aborts the frame with no strobe; after release, decoding restarts from IDLE.
- rx_s is i_Rx_Data after SYNC_STAGES flops. All FSM decisions use rx_s.
- Counters and state advance only on clk cycles with i_Rx_Tick=1. With the tick held low, everything holds.
- Tick counter width is clog2(RX_OVERSAMPLE). Bit counter width is clog2(DATA_BITS+1).
- IDLE: on a tick with rx_s=0, go to START and clear the tick counter.
- START: count ticks. At tick count RX_OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA, clear tick and bit counters.
  - rx_s=1: treat as a glitch and return to IDLE with no strobe.
- DATA: at tick count RX_OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift, so LSB-first data lands in order), clear the tick counter, increment the bit counter. After the DATA_BITS-th sample, go to STOP.
- STOP: at tick count RX_OVERSAMPLE-1, sample rx_s.
  - rx_s=1: register o_Rx_Byte = shift register and pulse o_Rx_Done for exactly one clk on the following cycle, then go to IDLE.
  - rx_s=0: pulse o_Rx_Frame_Err for one clk, leave o_Rx_Byte unchanged, go to BREAK.
- BREAK: wait for a tick with rx_s=1, then go to IDLE. A line held low (break condition) produces no further strobes.
- o_Rx_Done and o_Rx_Frame_Err are never high in the same cycle. Each is high for exactly one clk per frame regardless of tick spacing.
- o_Rx_Byte holds its value between successful frames.
- Back-to-back frames: a start edge seen on the first tick after returning to IDLE is accepted, so there is no dead time beyond the stop bit's half period.
- Ticks on consecutive clk cycles (tick tied high) are legal.

Test Plan:
- RX_OVERSAMPLE=16, tick every 4 clk, send 0xA5 8N1 -> one o_Rx_Done pulse, o_Rx_Byte=0xA5, o_Rx_Frame_Err never high, o_Rx_Active high from start detect to stop sample.
- Line low for 4 ticks then high -> returns to IDLE, no o_Rx_Done, no o_Rx_Frame_Err, o_Rx_Byte still 0x00.
- Send 0x3C with stop bit forced low, then hold line low 40 ticks, then release -> single o_Rx_Frame_Err pulse, no o_Rx_Done, o_Rx_Byte unchanged. Next valid 0x81 decodes correctly.
- Back-to-back 0x00 then 0xFF with no idle gap -> two o_Rx_Done pulses with bytes 0x00, 0xFF in order.
- Assert reset_n low during DATA bit 4 of 0x55, release, send 0xC3 -> no strobe for the aborted frame, all outputs 0 during reset, then o_Rx_Byte=0xC3 with a single done pulse.
- Tick tied high vs tick every 7 clk with a random 10-clk stall mid-frame, sending 0x6E -> both decode 0x6E, done pulse width exactly 1 clk.
